// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO register control block.
package hilo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int DEFAULT_LATENCY = 32;

endpackage

// File: rtl/hilo_cycle_counter.sv
// Operation cycle counter: synchronous clear, count enable, terminal at LATENCY-1.
module hilo_cycle_counter #(
    parameter int LATENCY = 32,
    parameter int CW      = $clog2(LATENCY) + 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [CW-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // One extra bit of width means the final increment to LATENCY cannot wrap.
    assign terminal = (count == CW'(LATENCY - 1));

endmodule

// File: rtl/hilo_control.sv
// HI/LO architectural registers with mult/div result sequencing and mthi/mtlo writes.
// Optional macro HILO_DIV_ZERO_CHECK_EN rejects divides by zero with a divZero pulse.
module hilo_control
    import hilo_pkg::*;
#(
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        divOrMult,
    input  logic [31:0] multHi,
    input  logic [31:0] multLo,
    input  logic [31:0] divHi,
    input  logic [31:0] divLo,
    input  logic [31:0] divisor,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wrData,
    output logic [31:0] hiOut,
    output logic [31:0] loOut,
    output logic        busy,
    output logic        done,
    output logic        divZero,
    output state_t      fsm_state
);

    state_t state, state_next;
    logic   op_q;
    logic   launch;
    logic   accept;
    logic   load;
    logic   dz_hit;
    logic   cnt_clear;
    logic   cnt_enable;
    logic   cnt_terminal;
    logic   wr_ok;

    hilo_cycle_counter #(
        .LATENCY (LATENCY)
    ) u_counter (
        .clock    (clock),
        .reset    (reset),
        .clear    (cnt_clear),
        .enable   (cnt_enable),
        .terminal (cnt_terminal)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        accept     = 1'b0;
        load       = 1'b0;
        dz_hit     = 1'b0;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;
        case (state)
            IDLE: begin
                launch = start;
`ifdef HILO_DIV_ZERO_CHECK_EN
                if (start && divOrMult == OP_DIV && divisor == 32'd0) begin
                    launch = 1'b0;
                    dz_hit = 1'b1;
                end
`endif
                if (launch) begin
                    accept     = 1'b1;
                    cnt_clear  = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                cnt_enable = 1'b1;
                if (cnt_terminal) begin
                    load       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q <= OP_MULT;
        end else if (accept) begin
            op_q <= divOrMult;
        end
    end

    // Direct writes are locked out only while an operation is in flight.
    assign wr_ok = (state != RUN);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hiOut <= '0;
        end else if (load) begin
            hiOut <= (op_q == OP_DIV) ? divHi : multHi;
        end else if (mthi && wr_ok) begin
            hiOut <= wrData;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            loOut <= '0;
        end else if (load) begin
            loOut <= (op_q == OP_DIV) ? divLo : multLo;
        end else if (mtlo && wr_ok) begin
            loOut <= wrData;
        end
    end

`ifdef HILO_DIV_ZERO_CHECK_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            divZero <= 1'b0;
        end else begin
            divZero <= dz_hit;
        end
    end
`else
    logic unused_divisor;
    assign unused_divisor = ^{divisor, dz_hit};
    assign divZero        = 1'b0;
`endif

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign fsm_state = state;

endmodule

// File: tb/tb_hilo_control.sv
// Directed scoreboard bench for hilo_control: result loads, direct writes, stalls, reset abort.
module tb_hilo_control;
    import hilo_pkg::*;

    localparam int LATENCY = 32;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        divOrMult;
    logic [31:0] multHi, multLo, divHi, divLo, divisor;
    logic        mthi, mtlo;
    logic [31:0] wrData;
    logic [31:0] hiOut, loOut;
    logic        busy, done, divZero;
    state_t      fsm_state;

    int n_compared   = 0;
    int n_mismatched = 0;
    int n_done       = 0;
    logic [63:0] exp_q[$];

    hilo_control #(.LATENCY(LATENCY)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .divOrMult (divOrMult),
        .multHi    (multHi),
        .multLo    (multLo),
        .divHi     (divHi),
        .divLo     (divLo),
        .divisor   (divisor),
        .mthi      (mthi),
        .mtlo      (mtlo),
        .wrData    (wrData),
        .hiOut     (hiOut),
        .loOut     (loOut),
        .busy      (busy),
        .done      (done),
        .divZero   (divZero),
        .fsm_state (fsm_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: every done pulse must match the oldest pending expected result
    always @(negedge clock) begin
        if (!reset && done === 1'b1) begin
            n_done++;
            if (exp_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("FAIL unexpected_done: got hi=%h lo=%h expected no result", hiOut, loOut);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("result_hi", hiOut, e[63:32]);
                check("result_lo", loOut, e[31:0]);
            end
        end
    end

    // driver: start one op; optional stray start at cycle 5 and mtlo at cycle 7
    task automatic run_op(input bit inject, input bit chk_wr, input logic [31:0] wr_exp);
        logic [31:0] lo_before;
        lo_before = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        if (chk_wr) check("same_cycle_mthi", hiOut, wr_exp);
        for (int k = 0; k < LATENCY; k++) begin
            check("busy_run", {31'b0, busy}, 32'd1);
            check("done_run", {31'b0, done}, 32'd0);
            if (inject && k == 8) check("mtlo_in_run_ignored", loOut, lo_before);
            if (inject && k == 5) begin
                start     = 1'b1;
                divOrMult = ~divOrMult;
            end
            if (inject && k == 7) begin
                lo_before = loOut;
                mtlo      = 1'b1;
                wrData    = 32'hBAD0_0000;
            end
            tick();
            start = 1'b0;
            mtlo  = 1'b0;
        end
        check("done_pulse", {31'b0, done}, 32'd1);
        check("busy_done", {31'b0, busy}, 32'd0);
        tick();
        check("done_one_cycle", {31'b0, done}, 32'd0);
        check("busy_idle", {31'b0, busy}, 32'd0);
        check("state_idle", {30'b0, fsm_state}, {30'b0, IDLE});
    endtask

    initial begin
        int exp_done;
        exp_done  = 0;
        reset     = 1'b1;
        start     = 1'b0;
        divOrMult = OP_MULT;
        multHi    = '0; multLo = '0; divHi = '0; divLo = '0; divisor = '0;
        mthi      = 1'b0; mtlo = 1'b0; wrData = '0;
        #2;
        check("rst_hi", hiOut, 32'd0);
        check("rst_lo", loOut, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_divzero", {31'b0, divZero}, 32'd0);
        check("rst_state", {30'b0, fsm_state}, {30'b0, IDLE});
        tick(); tick();
        reset = 1'b0;
        tick();

        // direct writes in IDLE
        mthi = 1'b1; wrData = 32'hDEAD_BEEF;
        tick();
        mthi = 1'b0;
        check("mthi_idle", hiOut, 32'hDEAD_BEEF);
        check("mthi_lo_untouched", loOut, 32'd0);
        mtlo = 1'b1; wrData = 32'h1234_5678;
        tick();
        mtlo = 1'b0;
        check("mtlo_idle", loOut, 32'h1234_5678);
        mthi = 1'b1; mtlo = 1'b1; wrData = 32'h0F0F_A5A5;
        tick();
        mthi = 1'b0; mtlo = 1'b0;
        check("both_hi", hiOut, 32'h0F0F_A5A5);
        check("both_lo", loOut, 32'h0F0F_A5A5);

        // multiply with stray start and mtlo during RUN
        multHi = 32'h0000_0001; multLo = 32'hFFFF_FFFE; divOrMult = OP_MULT;
        divHi  = 32'h5555_5555; divLo = 32'h6666_6666;
        exp_q.push_back({32'h0000_0001, 32'hFFFF_FFFE});
        exp_done++;
        run_op(1'b1, 1'b0, 32'd0);

        // divide
        divHi = 32'd3; divLo = 32'd7; divisor = 32'd5; divOrMult = OP_DIV;
        multHi = 32'h7777_7777; multLo = 32'h8888_8888;
        exp_q.push_back({32'd3, 32'd7});
        exp_done++;
        run_op(1'b0, 1'b0, 32'd0);
        check("div_divzero_low", {31'b0, divZero}, 32'd0);

        // divide by zero
        divHi = 32'hCAFE_0001; divLo = 32'hCAFE_0002; divisor = 32'd0; divOrMult = OP_DIV;
`ifdef HILO_DIV_ZERO_CHECK_EN
        start = 1'b1;
        tick();
        start = 1'b0;
        check("dz_pulse", {31'b0, divZero}, 32'd1);
        check("dz_busy", {31'b0, busy}, 32'd0);
        check("dz_state", {30'b0, fsm_state}, {30'b0, IDLE});
        tick();
        check("dz_pulse_end", {31'b0, divZero}, 32'd0);
        check("dz_busy2", {31'b0, busy}, 32'd0);
        check("dz_hi_kept", hiOut, 32'd3);
        check("dz_lo_kept", loOut, 32'd7);
`else
        exp_q.push_back({32'hCAFE_0001, 32'hCAFE_0002});
        exp_done++;
        run_op(1'b0, 1'b0, 32'd0);
        check("dz_disabled_low", {31'b0, divZero}, 32'd0);
`endif

        // start and mthi in the same IDLE cycle: write lands, result overwrites
        multHi = 32'd5; multLo = 32'd6; divOrMult = OP_MULT; divisor = 32'd1;
        mthi = 1'b1; wrData = 32'hAAAA_AAAA;
        exp_q.push_back({32'd5, 32'd6});
        exp_done++;
        run_op(1'b0, 1'b1, 32'hAAAA_AAAA);

        // reset during RUN aborts the operation
        multHi = 32'h9999_9999; multLo = 32'h9999_9999;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check("pre_abort_busy", {31'b0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("abort_hi", hiOut, 32'd0);
        check("abort_lo", loOut, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_state", {30'b0, fsm_state}, {30'b0, IDLE});
        tick(); tick();
        reset = 1'b0;
        for (int k = 0; k < LATENCY + 8; k++) tick();
        check("post_abort_hi", hiOut, 32'd0);
        check("post_abort_lo", loOut, 32'd0);
        check("post_abort_busy", {31'b0, busy}, 32'd0);

        // final report
        check("done_count", n_done, exp_done);
        check("pending_results", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
